// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory responder: FSM states, length/source codes,
// RAM data width and the length-to-byte-count decode.
package mem_ctrl_pkg;

   localparam int unsigned RAM_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      LEN_BYTE = 2'd0,
      LEN_HALF = 2'd1,
      LEN_WORD = 2'd2,
      LEN_RSVD = 2'd3
   } len_e;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_LS = 1'b1
   } src_e;

   // Reserved length code behaves as a word access.
   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      case (len)
         LEN_BYTE: return 3'd1;
         LEN_HALF: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request ports and byte-wide RAM bus of the memory responder.
interface mem_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   import mem_ctrl_pkg::*;

   logic              if_read;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [31:0]       if_data;

   logic              ls_read;
   logic              ls_write;
   logic [ADDR_W-1:0] ls_addr;
   logic [1:0]        ls_len;
   logic [31:0]       ls_wdata;
   logic              ls_ready;
   logic [31:0]       ls_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wr;
   logic [RAM_DW-1:0] ram_dout;
   logic [RAM_DW-1:0] ram_din;

   modport slave (
      input  if_read, if_addr, ls_read, ls_write, ls_addr, ls_len, ls_wdata, ram_din,
      output if_ready, if_data, ls_ready, ls_rdata, ram_addr, ram_wr, ram_dout
   );

   modport master (
      output if_read, if_addr, ls_read, ls_write, ls_addr, ls_len, ls_wdata, ram_din,
      input  if_ready, if_data, ls_ready, ls_rdata, ram_addr, ram_wr, ram_dout
   );

endinterface

// File: rtl/mem_ctrl_ram_byte_seq.sv
// Byte sequencer: walks base..base+n-1 on the RAM port, drives write bytes
// and assembles read bytes little-endian.
module ram_byte_seq
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic              active_i,
   input  logic              wr_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [2:0]        nbytes_i,
   input  logic [31:0]       wdata_i,
   input  logic [RAM_DW-1:0] ram_din_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [RAM_DW-1:0] ram_dout_o,
   output logic              last_o,
   output logic [31:0]       rdata_o
);

   localparam logic [2:0] LAT = 3'(RAM_LAT);

   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        n_q, n_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [31:0]       asm_q, asm_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ram_wr_q, ram_wr_d;
   logic [RAM_DW-1:0] dout_q, dout_d;
   logic [1:0]        cap_idx;

   // cnt_q equals j at edge E_j; the byte addressed after E_i returns at E_(i+LAT+1).
   always_comb begin
      cnt_d    = cnt_q;
      n_d      = n_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      asm_d    = asm_q;
      addr_d   = addr_q;
      ram_wr_d = 1'b0;
      dout_d   = dout_q;
      last_o   = 1'b0;
      cap_idx  = 2'(cnt_q - (LAT + 3'd1));
      if (start_i) begin
         cnt_d    = 3'd1;
         n_d      = nbytes_i;
         base_d   = base_i;
         wdata_d  = wdata_i;
         wr_d     = wr_i;
         asm_d    = '0;
         addr_d   = base_i;
         ram_wr_d = wr_i;
         if (wr_i) dout_d = wdata_i[7:0];
      end else if (active_i) begin
         cnt_d = cnt_q + 3'd1;
         if (cnt_q < n_q) begin
            addr_d   = base_q + ADDR_W'(cnt_q);
            ram_wr_d = wr_q;
            if (wr_q) dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
         end
         if (!wr_q && cnt_q >= LAT + 3'd1) asm_d[{cap_idx, 3'b000} +: 8] = ram_din_i;
         last_o = wr_q ? (cnt_q == n_q) : (cnt_q == n_q + LAT);
      end else begin
         cnt_d = '0;
      end
      rdata_o = asm_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         n_q      <= '0;
         base_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         asm_q    <= '0;
         addr_q   <= '0;
         ram_wr_q <= 1'b0;
         dout_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         asm_q    <= asm_d;
         addr_q   <= addr_d;
         ram_wr_q <= ram_wr_d;
         dout_q   <= dout_d;
      end
   end

   assign ram_addr_o = addr_q;
   assign ram_wr_o   = ram_wr_q;
   assign ram_dout_o = dout_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory responder: arbitrates fetch and load/store requests onto a byte-wide
// single-port RAM, handles fetch withdrawal and routes the ready pulses.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned RAM_LAT = 1
) (
   input logic       clk,
   input logic       reset,
   mem_ctrl_if.slave bus
);

   state_e      state_q, state_d;
   src_e        src_q, src_d;
   logic        abort_q, abort_d;
   logic        if_ready_q, if_ready_d;
   logic        ls_ready_q, ls_ready_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;

   logic              seq_start;
   logic              seq_wr;
   logic [ADDR_W-1:0] seq_base;
   logic [2:0]        seq_n;
   logic              seq_active;
   logic              seq_last;
   logic [31:0]       seq_rdata;

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      abort_d    = abort_q;
      if_ready_d = 1'b0;
      ls_ready_d = 1'b0;
      if_data_d  = if_data_q;
      ls_rdata_d = ls_rdata_q;
      seq_start  = 1'b0;
      seq_wr     = 1'b0;
      seq_base   = bus.ls_addr;
      seq_n      = len_bytes(bus.ls_len);
      case (state_q)
         ST_IDLE: begin
            if (bus.ls_write) begin
               seq_start = 1'b1;
               seq_wr    = 1'b1;
               src_d     = SRC_LS;
               state_d   = ST_WRITE;
            end else if (bus.ls_read) begin
               seq_start = 1'b1;
               src_d     = SRC_LS;
               state_d   = ST_READ;
            end else if (bus.if_read) begin
               seq_start = 1'b1;
               seq_base  = bus.if_addr;
               seq_n     = 3'd4;
               src_d     = SRC_IF;
               abort_d   = 1'b0;
               state_d   = ST_READ;
            end
         end
         ST_READ: begin
            // A withdrawn fetch still runs its byte sequence; only the result is dropped.
            if (src_q == SRC_IF && !bus.if_read) abort_d = 1'b1;
            if (seq_last) begin
               state_d = ST_DONE;
               if (src_q == SRC_LS) begin
                  ls_ready_d = 1'b1;
                  ls_rdata_d = seq_rdata;
               end else if (!abort_d) begin
                  if_ready_d = 1'b1;
                  if_data_d  = seq_rdata;
               end
            end
         end
         ST_WRITE: begin
            if (seq_last) begin
               state_d    = ST_DONE;
               ls_ready_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         src_q      <= SRC_IF;
         abort_q    <= 1'b0;
         if_ready_q <= 1'b0;
         ls_ready_q <= 1'b0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         abort_q    <= abort_d;
         if_ready_q <= if_ready_d;
         ls_ready_q <= ls_ready_d;
         if_data_q  <= if_data_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   assign seq_active = (state_q == ST_READ) || (state_q == ST_WRITE);

   ram_byte_seq #(
      .ADDR_W  (ADDR_W),
      .RAM_LAT (RAM_LAT)
   ) u_seq (
      .clk        (clk),
      .reset      (reset),
      .start_i    (seq_start),
      .active_i   (seq_active),
      .wr_i       (seq_wr),
      .base_i     (seq_base),
      .nbytes_i   (seq_n),
      .wdata_i    (bus.ls_wdata),
      .ram_din_i  (bus.ram_din),
      .ram_addr_o (bus.ram_addr),
      .ram_wr_o   (bus.ram_wr),
      .ram_dout_o (bus.ram_dout),
      .last_o     (seq_last),
      .rdata_o    (seq_rdata)
   );

   assign bus.if_ready = if_ready_q;
   assign bus.if_data  = if_data_q;
   assign bus.ls_ready = ls_ready_q;
   assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// checked against a transaction-level memory model.
module tb_mem_ctrl;

   localparam int K_IF = 0, K_LD = 1, K_ST = 2, K_RW = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_ctrl_if #(.ADDR_W(32)) bus ();

   mem_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic [7:0]  ram  [logic [31:0]];
   logic [7:0]  refm [logic [31:0]];
   logic [39:0] wq [$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_if = '0;
   logic [31:0] last_ls = '0;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (refm.exists(a)) return refm[a];
      return init_byte(a);
   endfunction

   // Synchronous byte RAM, read-before-write, one cycle read latency.
   always @(posedge clk) begin
      bus.ram_din <= ram_rd(bus.ram_addr);
      if (bus.ram_wr === 1'b1) ram[bus.ram_addr] = bus.ram_dout;
   end

   always @(negedge clk)
      if (bus.ram_wr === 1'b1) wq.push_back({bus.ram_addr, bus.ram_dout});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_read  = 1'b0;
      bus.ls_read  = 1'b0;
      bus.ls_write = 1'b0;
   endtask

   task automatic do_req(input int kind, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wd);
      int n, lat, got, other;
      bit st;
      logic [31:0] exp, got_data;
      st  = (kind == K_ST) || (kind == K_RW);
      n   = (kind == K_IF || len >= 2'd2) ? 4 : int'(len) + 1;
      lat = st ? n : n + 1;
      exp = '0;
      for (int i = 0; i < n; i++) exp |= 32'(ref_rd(addr + 32'(i))) << (8 * i);
      wq.delete();
      bus.if_read  = (kind == K_IF);
      bus.ls_read  = (kind == K_LD) || (kind == K_RW);
      bus.ls_write = st;
      bus.if_addr  = addr;
      bus.ls_addr  = addr;
      bus.ls_len   = len;
      bus.ls_wdata = wd;
      got = 0; other = 0; got_data = '0;
      cyc();
      for (int c = 1; c <= 12 && got == 0; c++) begin
         cyc();
         if ((kind == K_IF) ? bus.if_ready : bus.ls_ready) begin
            got = c;
            got_data = (kind == K_IF) ? bus.if_data : bus.ls_rdata;
         end
         if ((kind == K_IF) ? bus.ls_ready : bus.if_ready) other++;
      end
      idle_inputs();
      check("latency", 32'(got), 32'(lat));
      check("other_ready", 32'(other), 32'd0);
      if (kind == K_IF) begin
         check("if_data", got_data, exp);
         check("ls_hold", bus.ls_rdata, last_ls);
         last_if = exp;
      end else if (kind == K_LD) begin
         check("ls_rdata", got_data, exp);
         check("if_hold", bus.if_data, last_if);
         last_ls = exp;
      end else begin
         check("ls_hold_st", bus.ls_rdata, last_ls);
      end
      cyc();
      check("ready_pulse", 32'({bus.if_ready, bus.ls_ready}), 32'd0);
      if (st) begin
         check("wr_count", 32'(wq.size()), 32'(n));
         for (int i = 0; i < n && i < wq.size(); i++) begin
            check("wr_addr", wq[i][39:8], addr + 32'(i));
            check("wr_byte", 32'(wq[i][7:0]), 32'(wd[8*i +: 8]));
         end
         for (int i = 0; i < n; i++) refm[addr + 32'(i)] = wd[8*i +: 8];
      end else begin
         check("no_write", 32'(wq.size()), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ls_c, if_c, both, cnt;
      logic [31:0] got_ls, got_if, wd, a;

      idle_inputs();
      bus.if_addr = '0; bus.ls_addr = '0; bus.ls_len = '0; bus.ls_wdata = '0;
      reset = 1'b1;
      cyc();
      cyc();
      check("rst_if_ready", 32'(bus.if_ready), 32'd0);
      check("rst_ls_ready", 32'(bus.ls_ready), 32'd0);
      check("rst_ram_wr",   32'(bus.ram_wr), 32'd0);
      check("rst_ram_addr", bus.ram_addr, 32'd0);
      check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
      check("rst_if_data",  bus.if_data, 32'd0);
      check("rst_ls_rdata", bus.ls_rdata, 32'd0);
      reset = 1'b0;
      cyc();

      // Preloaded word fetch.
      for (int i = 0; i < 4; i++) begin
         wd = 32'h12345678;
         ram[32'h100 + 32'(i)]  = wd[8*i +: 8];
         refm[32'h100 + 32'(i)] = wd[8*i +: 8];
      end
      do_req(K_IF, 32'h100, 2'd2, '0);
      do_req(K_ST, 32'h1FF, 2'd1, 32'hAABBCCDD);
      do_req(K_LD, 32'h200, 2'd0, '0);

      // Simultaneous load and fetch: load first, fetch after its DONE.
      bus.ls_read = 1'b1; bus.ls_addr = 32'h100; bus.ls_len = 2'd2;
      bus.if_read = 1'b1; bus.if_addr = 32'h200;
      wq.delete();
      ls_c = 0; if_c = 0; both = 0; got_ls = '0; got_if = '0;
      cyc();
      for (int c = 1; c <= 14; c++) begin
         cyc();
         if (bus.if_ready && bus.ls_ready) both++;
         if (bus.ls_ready && ls_c == 0) begin ls_c = c; got_ls = bus.ls_rdata; bus.ls_read = 1'b0; end
         if (bus.if_ready && if_c == 0) begin if_c = c; got_if = bus.if_data; bus.if_read = 1'b0; end
      end
      idle_inputs();
      check("arb_ls_lat", 32'(ls_c), 32'd5);
      check("arb_if_lat", 32'(if_c), 32'd12);
      check("arb_both", 32'(both), 32'd0);
      check("arb_ls_data", got_ls, 32'h12345678);
      wd = {ref_rd(32'h203), ref_rd(32'h202), ref_rd(32'h201), ref_rd(32'h200)};
      check("arb_if_data", got_if, wd);
      check("arb_no_write", 32'(wq.size()), 32'd0);
      last_ls = 32'h12345678;
      last_if = wd;

      // Fetch withdrawn before E2: sequence runs, no pulse, data held.
      bus.if_read = 1'b1; bus.if_addr = 32'h300;
      cyc();
      cyc();
      bus.if_read = 1'b0;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         cyc();
         if (bus.if_ready) cnt++;
      end
      check("abort_ready", 32'(cnt), 32'd0);
      check("abort_data", bus.if_data, last_if);
      do_req(K_IF, 32'h200, 2'd2, '0);

      do_req(K_LD, 32'hFFFFFFFE, 2'd2, '0);
      do_req(K_IF, 32'hFFFFFFFF, 2'd2, '0);

      // Reset at E2 of a word store: two bytes land, no ready.
      bus.ls_write = 1'b1; bus.ls_addr = 32'h400; bus.ls_len = 2'd2; bus.ls_wdata = 32'h11223344;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      check("rst_mid_wr", 32'(bus.ram_wr), 32'd0);
      check("rst_mid_rdy", 32'(bus.ls_ready), 32'd0);
      reset = 1'b0;
      idle_inputs();
      cyc();
      check("rst_after_wr", 32'(bus.ram_wr), 32'd0);
      check("rst_after_rdy", 32'(bus.ls_ready), 32'd0);
      refm[32'h400] = 8'h44;
      refm[32'h401] = 8'h33;
      for (int i = 0; i < 4; i++)
         check("rst_mem", 32'(ram_rd(32'h400 + 32'(i))), 32'(ref_rd(32'h400 + 32'(i))));
      last_if = '0;
      last_ls = '0;
      do_req(K_LD, 32'h400, 2'd2, '0);

      for (int t = 0; t < 60; t++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                          : 32'h500 + 32'($urandom_range(0, 31));
         do_req(int'($urandom_range(0, 3)), a, 2'($urandom_range(0, 3)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory responder serving the CPU's 32-bit request ports over a byte-wide, synchronous single-port RAM.
- Two requesters:
  - Instruction fetch: read-only, word.
  - Load/store unit: read/write, byte/half/word.
- Arbitrates between them and sequences each request into 1/2/4 byte accesses.
- Returns little-endian assembled data with a one-cycle ready pulse.

Parameters:
ADDR_W, 32, address width of all ports; RAM address width as well.
RAM_LAT, 1, RAM read latency in cycles; fixed, only 1 supported.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
if_read  in  1  fetch request, held until if_ready or withdrawn
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction
ls_read  in  1  load request, held until ls_ready
ls_write  in  1  store request, held until ls_ready
ls_addr  in  ADDR_W  load/store address
ls_len  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
ls_wdata  in  32  store data, low bytes used
ls_ready  out  1  one-cycle pulse: load data valid / store complete
ls_rdata  out  32  load data, zero-extended (sign extension done by load unit)
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  1=write, 0=read
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid the cycle after its address

Behaviour:
- Reset values (visible the cycle after the reset edge): state IDLE, ram_wr=0, ram_addr=0, ram_dout=0, if_ready=0, ls_ready=0, if_data=0, ls_rdata=0, byte counters 0.
- States:
  - IDLE: sample requests at each edge.
  - READ: issue addresses and capture bytes.
  - WRITE: issue write bytes.
  - DONE: ready high for one cycle, then IDLE.
- Acceptance: only in IDLE.
  - Priority: ls_write > ls_read > if_read.
  - At accept edge E0, latch base address, length n (1/2/4; fetch always 4), wdata and source.
- Read timing:
  - Byte i address base+i is driven with ram_wr=0 in the cycle after edge E_i, for i=0..n-1.
  - Byte i is captured from ram_din at E_(i+2).
  - The ready pulse and data are registered at E_(n+1) and are high between E_(n+1) and E_(n+2).
  - Word read: accept at E0, ready at E5. Byte read: ready at E2.
- Write timing:
  - ram_wr=1, ram_addr=base+i, ram_dout=wdata[8i+7:8i] in the cycle after E_i, for i=0..n-1.
  - ram_wr returns to 0 at E_n, together with ls_ready high for one cycle.
  - Word store: ready at E4.
- Data assembly: little-endian, byte i goes to bits [8i+7:8i]. Unfilled upper bytes are 0.
- Ready/data hold: data outputs hold their last value after the pulse. Ready is never high in two consecutive cycles.
- Requester rule: the requester may drop its request during the ready cycle. DONE guarantees no same-cycle re-accept. A request still high after DONE is accepted again as a new transaction.
- Fetch withdrawal: if if_read is 0 at any edge during an accepted fetch (branch redirect), the transfer still completes its byte sequence, but if_ready is suppressed and if_data is not updated. A new fetch is accepted on the next IDLE.
- Stores are never aborted.
- Address arithmetic: base+i modulo 2^ADDR_W; wrap at all-ones to 0. Unaligned addresses are legal and need no alignment check.
- ls_read and ls_write both high: treated as a write. ls_len=3: treated as word.
- Reset mid-operation: IDLE at the next edge with ram_wr=0; no ready pulse. Bytes already written stay written.
- ram_addr in IDLE holds its last value; ram_wr is 0 outside WRITE.

Decomposition:
- Shared package/define file: state encodings (IDLE/READ/WRITE/DONE), len codes, source codes (SRC_IF/SRC_LS), 8-bit RAM data width.
- One natural sub-module, ram_byte_seq: owns the byte counter, address increment, RAM drive and byte assembly. mem_ctrl keeps the arbitration, abort handling and ready routing.

Test Plan:
- RAM[0x100..0x103]=78 56 34 12; if_read=1, if_addr=0x100 accepted at E0 -> if_ready exactly at E5, if_data=0x12345678, ram_wr stays 0.
- ls_write=1, len=1, addr=0x1FF, wdata=0xAABBCCDD -> ram_wr=1 for 2 cycles at addresses 0x1FF then 0x200 with bytes DD then CC; ls_ready at E2. A following byte read of 0x200 returns ls_rdata=0x000000CC at E2.
- if_read and ls_read high in the same IDLE cycle -> load served first, if_ready follows its own 5-cycle sequence, no overlap, never both ready in one cycle.
- Fetch accepted, if_read dropped at E2 -> no if_ready pulse, if_data unchanged; a new fetch at 0x200 is accepted after DONE and returns correct data.
- Word read at addr 0xFFFFFFFE (ADDR_W=32) -> RAM addresses FFFFFFFE, FFFFFFFF, 0, 1; correct little-endian assembly.
- reset asserted at E2 of a word write -> IDLE next edge, ram_wr=0, no ls_ready. Bytes 0-1 are written, bytes 2-3 are untouched.
